seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 91 +++++++++
 tb/tb_seq_detector_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable PAT_W-bit serial pattern detector with overlap mode and saturating match count.
// Optional SEQ_DET_MASK_EN adds a per-bit compare mask loaded alongside the pattern.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011),
    parameter bit               RST_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             ovl_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             clr_cnt,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FMAX = FW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, FILLING, ARMED} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] cand;
    logic             hit, match, consume;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif

    always_comb begin
        cand    = {hist_q, din};
`ifdef SEQ_DET_MASK_EN
        hit     = ((cand ^ pat_q) & mask_q) == '0;
        mask_d  = load ? pat_mask : mask_q;
`else
        hit     = cand == pat_q;
`endif
        match   = din_valid && !load && state_q == ARMED && hit;
        // a non-overlapping match consumes its bits just like a reload does
        consume = load || (match && !ovl_q);
        pat_d   = load ? pat_in : pat_q;
        ovl_d   = load ? ovl_in : ovl_q;
        hist_d  = consume ? '0 : din_valid ? cand[PAT_W-2:0] : hist_q;
        fill_d  = consume ? '0 : (din_valid && fill_q != FMAX) ? fill_q + FW'(1) : fill_q;
        dout_d  = match;
        cnt_d   = clr_cnt ? '0 : (match && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        state_d = fill_d == '0 ? IDLE : fill_d == FMAX ? ARMED : FILLING;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= RST_PAT;
            ovl_q   <= RST_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign armed     = state_q == ARMED;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized + directed scoreboard bench with a queue-of-bits reference model.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, din_valid = 1'b0, din = 1'b0, load = 1'b0, ovl_in = 1'b0, clr_cnt = 1'b0;
    logic [3:0] pat_in = '0, pat_mask = '1;
    logic       dout, armed;
    logic [2:0] match_cnt;

    typedef struct packed {logic d; logic [2:0] c; logic a;} exp_t;
    exp_t q[$];
    int checks = 0, passes = 0;

    bit         hist[$];
    logic [3:0] m_pat = 4'b1011, m_mask = '1;
    bit         m_ovl = 1'b1;
    int         m_cnt = 0;

    seq_detector_param #(.PAT_W(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .load(load),
        .pat_in(pat_in), .ovl_in(ovl_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .clr_cnt(clr_cnt), .dout(dout), .match_cnt(match_cnt), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    endtask

    // drive one cycle of inputs and push the model's expected outputs for after the next edge
    task automatic step(input logic r, input logic ld, input logic [3:0] p, input logic o,
                        input logic c, input logic v, input logic dd, input logic [3:0] mk);
        exp_t       e;
        bit         hit;
        logic [3:0] cand;
        @(posedge clk);
        #2;
        rst_n = r; load = ld; pat_in = p; ovl_in = o; clr_cnt = c; din_valid = v; din = dd; pat_mask = mk;
        hit = 1'b0;
        if (!r) begin
            m_pat = 4'b1011; m_ovl = 1'b1; m_mask = '1; m_cnt = 0;
            hist.delete();
        end else begin
            if (ld) begin
                m_pat = p; m_ovl = o;
`ifdef SEQ_DET_MASK_EN
                m_mask = mk;
`endif
                hist.delete();
            end else if (v) begin
                if (hist.size() == 3) begin
                    cand = {hist[0], hist[1], hist[2], dd};
                    hit = ((cand ^ m_pat) & m_mask) == 4'b0;
                end
                if (hit && !m_ovl) hist.delete();
                else begin
                    hist.push_back(dd);
                    if (hist.size() > 3) void'(hist.pop_front());
                end
            end
            m_cnt = c ? 0 : (hit && m_cnt < 7) ? m_cnt + 1 : m_cnt;
        end
        e.d = hit;
        e.c = 3'(m_cnt);
        e.a = hist.size() == 3;
        q.push_back(e);
    endtask

    task automatic send(input int n, input logic [31:0] s, input logic c);
        for (int i = n - 1; i >= 0; i--) step(1, 0, 4'b0, 0, c, 1, s[i], 4'hf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'b0, 0, 0, 0, 0, 4'hf);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dout", int'(dout), int'(e.d));
                chk("match_cnt", int'(match_cnt), int'(e.c));
                chk("armed", int'(armed), int'(e.a));
            end
        end
    end

    initial begin : stim
        step(0, 0, 4'b0, 0, 0, 0, 0, 4'hf);
        step(0, 0, 4'b0, 0, 0, 1, 1, 4'hf);
        send(7, 32'b1011011, 0);
        idle(1);
        step(1, 1, 4'b1011, 0, 0, 0, 0, 4'hf);
        send(10, 32'b1011011011, 0);
        step(1, 1, 4'b1111, 1, 1, 0, 0, 4'hf);
        send(2, 32'b11, 0);
        idle(2);
        send(4, 32'b1111, 0);
        send(8, 32'hff, 0);
        send(1, 32'b1, 1);
        send(2, 32'b11, 0);
        step(1, 1, 4'b1011, 1, 0, 0, 0, 4'hf);
        send(3, 32'b101, 0);
        step(1, 1, 4'b1011, 1, 0, 1, 1, 4'hf);
        send(4, 32'b0110, 0);
        send(3, 32'b101, 0);
        step(0, 0, 4'b0, 0, 0, 1, 1, 4'hf);
        send(5, 32'b11011, 0);
        step(1, 1, 4'b1001, 1, 0, 0, 0, 4'b1001);
        send(4, 32'b1111, 0);
        step(1, 1, 4'b1001, 1, 0, 0, 0, 4'b1001);
        send(4, 32'b0111, 0);
        step(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000);
        send(6, 32'b101100, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] p;
            p = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 4'hf : 4'h0) : 4'($urandom);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0, p, 1'($urandom),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 1) ? 4'hf : 4'($urandom));
        end
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
